alu_iter: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit combinational ALU of the von Neumann CPU datapath. It accepts one operation at a time through a valid/ready handshake, computes it in one cycle or iteratively, and returns a registered result with a registered flag vector. It sits between the operand registers and the writeback/flags path and lets the control unit stall on long operations: multi-bit shifts and the optional multiply.

---
 rtl/alu_iter.sv | 208 ++++++++++++++++++++
 tb/tb_alu_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU (ADD/AND/NOT/SHR/SUB/OR/SHL/MUL) with valid/ready in and out.
// Latency: 1 cycle for simple ops and zero-length shifts, 1+n for shifts, 1+WIDTH for MUL.
// Backpressure: the result is held in DONE until out_ready; no new op is accepted before then.
// Optional feature: define ALU_MUL_EN to build the iterative shift-add multiplier.
module alu_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [3:0]       flags
);
    localparam int SAW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SAW:0] CNT_ONE   = SAW'(1);
    localparam logic [SAW:0] CNT_WIDTH = (SAW+1)'(WIDTH);

    logic [1:0]       state;
    logic [2:0]       op_q;
    // Shift register for shifts; stays constant as the multiplicand for MUL.
    logic [WIDTH-1:0] opa;
    logic [SAW:0]     cnt;

    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [SAW-1:0]   n;
    logic             fin;
    logic             go_exec;
    logic [WIDTH-1:0] res_z;
    logic             res_c;
    logic             res_v;

    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign n       = b[SAW-1:0];

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

`ifdef ALU_MUL_EN
    // Accumulator holds {partial product, remaining multiplier bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nxt;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    assign acc_nxt = {mul_sum, acc[WIDTH-1:1]};
`endif

    // Result selection: single-cycle results in IDLE, last iteration step in EXEC.
    always_comb begin
        fin     = 1'b0;
        go_exec = 1'b0;
        res_z   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_ADD: begin
                            fin   = 1'b1;
                            res_z = sum_add[WIDTH-1:0];
                            res_c = sum_add[WIDTH];
                            res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            fin   = 1'b1;
                            res_z = sum_sub[WIDTH-1:0];
                            res_c = sum_sub[WIDTH];
                            res_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin   = 1'b1;
                            res_z = a & b;
                        end
                        OP_OR: begin
                            fin   = 1'b1;
                            res_z = a | b;
                        end
                        OP_NOT: begin
                            fin   = 1'b1;
                            res_z = ~a;
                        end
                        OP_SHR, OP_SHL: begin
                            if (n == '0) begin
                                fin   = 1'b1;
                                res_z = a;
                            end else begin
                                go_exec = 1'b1;
                            end
                        end
                        default: begin
`ifdef ALU_MUL_EN
                            go_exec = 1'b1;
`else
                            // Without the multiplier MUL retires at once with z = 0.
                            fin = 1'b1;
`endif
                        end
                    endcase
                end
            end
            S_EXEC: begin
                fin = (cnt == CNT_ONE);
                case (op_q)
                    OP_SHR: begin
                        res_z = opa >> 1;
                        res_c = opa[0];
                    end
                    OP_SHL: begin
                        res_z = opa << 1;
                        res_c = opa[WIDTH-1];
                    end
`ifdef ALU_MUL_EN
                    OP_MUL: begin
                        res_z = acc_nxt[WIDTH-1:0];
                        res_c = |acc_nxt[2*WIDTH-1:WIDTH];
                    end
`endif
                    default: begin
                        res_z = '0;
                    end
                endcase
            end
            default: begin
                fin = 1'b0;
            end
        endcase
    end

    // Control FSM, iteration datapath and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            opa   <= '0;
            cnt   <= '0;
            z     <= '0;
            flags <= '0;
`ifdef ALU_MUL_EN
            acc   <= '0;
`endif
        end else begin
            if (fin) begin
                z     <= res_z;
                flags <= {res_c, res_v, res_z[WIDTH-1], ~|res_z};
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        opa   <= a;
                        cnt   <= (op == OP_MUL) ? CNT_WIDTH : {1'b0, n};
`ifdef ALU_MUL_EN
                        acc   <= {{WIDTH{1'b0}}, b};
`endif
                        state <= go_exec ? S_EXEC : S_DONE;
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - CNT_ONE;
                    if (op_q == OP_SHR) begin
                        opa <= opa >> 1;
                    end else if (op_q == OP_SHL) begin
                        opa <= opa << 1;
                    end
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc <= acc_nxt;
                    end
`endif
                    if (fin) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: randomized and directed checks of alu_iter against an arithmetic reference model.
// Latency is measured from the accept edge to the first sample with out_valid high.
// Backpressure, ignored in_valid during DONE and mid-operation reset are exercised explicitly.
module tb_alu_iter;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  z;
    logic [3:0]    flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .flags(flags)
    );

    always #5 clk = ~clk;

    // Reference: result, {C,V,N,Z} and latency straight from the arithmetic rules.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] ez, output logic [3:0] ef, output int el);
        longint ux = x;
        longint uy = y;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        int     sh = int'(y % W);
        logic   c = 1'b0;
        logic   v = 1'b0;
        el = 1;
        ez = '0;
        case (o)
            3'b000: begin
                r  = ux + uy;
                ez = W'(r);
                c  = (r >= 65536);
                v  = (sx + sy > 32767) || (sx + sy < -32768);
            end
            3'b100: begin
                ez = W'(ux - uy);
                c  = (ux >= uy);
                v  = (sx - sy > 32767) || (sx - sy < -32768);
            end
            3'b001: ez = x & y;
            3'b101: ez = x | y;
            3'b010: ez = ~x;
            3'b011: begin
                ez = x >> sh;
                if (sh != 0) begin
                    c  = ((ux >> (sh - 1)) & 1) != 0;
                    el = 1 + sh;
                end
            end
            3'b110: begin
                ez = W'(ux << sh);
                if (sh != 0) begin
                    c  = ((ux >> (W - sh)) & 1) != 0;
                    el = 1 + sh;
                end
            end
            default: begin
`ifdef ALU_MUL_EN
                r  = ux * uy;
                ez = W'(r);
                c  = (r >> W) != 0;
                el = 1 + W;
`else
                ez = '0;
`endif
            end
        endcase
        ef = {c, v, ez[W-1], (ez == '0)};
    endfunction

    // Issue one op and wait (bounded) for its result; leaves the DUT in DONE.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] oz, output logic [3:0] of, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        oz = z;
        of = flags;
    endtask

    // Complete the output handshake.
    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (z !== '0) begin n_err++; $display("FAIL reset_z: got %h want 0000", z); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]   ops [8] = '{3'b000, 3'b100, 3'b100, 3'b011, 3'b110, 3'b011, 3'b111, 3'b111};
        logic [W-1:0] as  [8] = '{16'h7FFF, 16'h0005, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h0100, 16'h0003};
        logic [W-1:0] bs  [8] = '{16'h0001, 16'h0005, 16'h0001, 16'h0004, 16'h0001, 16'h0010, 16'h0100, 16'h0005};
        logic [W-1:0] gz, ez;
        logic [3:0]   gf, ef;
        int           gl, el;
        for (int i = 0; i < 8; i++) begin
            model(ops[i], as[i], bs[i], ez, ef, el);
            run_op(ops[i], as[i], bs[i], gz, gf, gl);
            n_cmp++; if (gz !== ez) begin n_err++; $display("FAIL dir%0d_z: got %h want %h", i, gz, ez); end
            n_cmp++; if (gf !== ef) begin n_err++; $display("FAIL dir%0d_flags: got %b want %b", i, gf, ef); end
            n_cmp++; if (gl !== el) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, gl, el); end
            finish_op();
        end
    endtask

    task automatic test_random();
        logic [2:0]   ro;
        logic [W-1:0] ra, rb, gz, ez;
        logic [3:0]   gf, ef;
        int           gl, el;
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 5 == 0) ra = (i % 10 == 0) ? 16'hFFFF : 16'h8000;
            if (i % 7 == 0) rb = W'($urandom_range(0, 3));
            model(ro, ra, rb, ez, ef, el);
            run_op(ro, ra, rb, gz, gf, gl);
            n_cmp++; if (gz !== ez) begin n_err++; $display("FAIL rnd%0d_z op=%0d a=%h b=%h: got %h want %h", i, ro, ra, rb, gz, ez); end
            n_cmp++; if (gf !== ef) begin n_err++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h: got %b want %b", i, ro, ra, rb, gf, ef); end
            n_cmp++; if (gl !== el) begin n_err++; $display("FAIL rnd%0d_latency op=%0d b=%h: got %0d want %0d", i, ro, rb, gl, el); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] gz;
        logic [3:0]   gf;
        int           gl;
        run_op(3'b000, 16'h0001, 16'h0002, gz, gf, gl);
        n_cmp++; if (gz !== 16'h0003) begin n_err++; $display("FAIL bp_z: got %h want 0003", gz); end
        n_cmp++; if (gl !== 1) begin n_err++; $display("FAIL bp_latency: got %0d want 1", gl); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            op = 3'b010;
            a = 16'h1234;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_out_valid: got %0b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d_in_ready: got %0b want 0", i, in_ready); end
            n_cmp++; if (z !== 16'h0003) begin n_err++; $display("FAIL bp%0d_z: got %h want 0003", i, z); end
            n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL bp%0d_flags: got %b want 0000", i, flags); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_op();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_ghost%0d_out_valid: got %0b want 0", i, out_valid); end
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] gz;
        logic [3:0]   gf;
        int           gl;
        int           ghost = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = 3'b111;
        a = 16'h00FF;
        b = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (z !== '0) begin n_err++; $display("FAIL rst_mid_z: got %h want 0000", z); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 0000", flags); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %0b want 1", in_ready); end
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        n_cmp++; if (ghost !== 0) begin n_err++; $display("FAIL rst_mid_stale: got %0d valid cycles want 0", ghost); end
        run_op(3'b000, 16'h0001, 16'h0002, gz, gf, gl);
        n_cmp++; if (gz !== 16'h0003) begin n_err++; $display("FAIL rst_add_z: got %h want 0003", gz); end
        n_cmp++; if (gf !== 4'b0000) begin n_err++; $display("FAIL rst_add_flags: got %b want 0000", gf); end
        n_cmp++; if (gl !== 1) begin n_err++; $display("FAIL rst_add_latency: got %0d want 1", gl); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
